// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryption core: one round per clock, on-the-fly key expansion,
// start/busy/done handshake. All 128-bit buses are [0:127], byte 0 = bits 0:7,
// column-major state.
// Optional feature macro: AES_LAST_KEY_OUT_EN adds the last_key output (round-10 key).
module aes128_encrypt_iter #(
  parameter int unsigned ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [0:127] key,
  input  logic [0:127] data,
  output logic         busy,
  output logic         done,
  output logic [0:127] en_key
`ifdef AES_LAST_KEY_OUT_EN
  ,
  output logic [0:127] last_key
`endif
);

  localparam logic [3:0] LastRnd = 4'(ROUNDS);

  typedef enum logic [1:0] {StIdle, StRound, StFinal} state_e;

  // GF(2^8) multiply by x, modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed algebraically: inverse as x^254 (maps 0 to 0), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] s;
    logic [7:0] b;
    s = x;
    b = 8'h01;
    for (int i = 0; i < 7; i++) begin
      s = gf_mul(s, s);
      b = gf_mul(b, s);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
           ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  state_e       st_q, st_d;
  logic [0:127] state_q, state_d;
  logic [0:127] rk_q, rk_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [0:127] en_key_q, en_key_d;
`ifdef AES_LAST_KEY_OUT_EN
  logic [0:127] last_key_q, last_key_d;
`endif

  logic [0:127] sb, sr, mc, rk_next;
  logic [0:31]  w3_sub, w0n, w1n, w2n, w3n;
  logic [7:0]   a0, a1, a2, a3;

  // Round datapath: SubBytes, ShiftRows, MixColumns on the current state.
  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    a0 = 8'h00;
    a1 = 8'h00;
    a2 = 8'h00;
    a3 = 8'h00;
    for (int i = 0; i < 16; i++) begin
      sb[8*i +: 8] = sbox(state_q[8*i +: 8]);
    end
    // Row r of column c takes the byte from column (c + r) mod 4.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[8*(4*c+r) +: 8] = sb[8*(4*((c+r)%4)+r) +: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[32*c +: 8];
      a1 = sr[32*c+8 +: 8];
      a2 = sr[32*c+16 +: 8];
      a3 = sr[32*c+24 +: 8];
      mc[32*c +: 8]    = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc[32*c+8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  end

  // Next round key from the current one: SubWord(RotWord(w3)) plus rcon for this round.
  always_comb begin
    w3_sub = '0;
    for (int j = 0; j < 4; j++) begin
      w3_sub[8*j +: 8] = sbox(rk_q[96 + 8*((j+1)%4) +: 8]);
    end
    w0n     = rk_q[0:31] ^ w3_sub ^ {rcon_of(rnd_q), 24'h000000};
    w1n     = rk_q[32:63] ^ w0n;
    w2n     = rk_q[64:95] ^ w1n;
    w3n     = rk_q[96:127] ^ w2n;
    rk_next = {w0n, w1n, w2n, w3n};
  end

  // Control FSM and next-state values for all registers.
  always_comb begin
    st_d       = st_q;
    state_d    = state_q;
    rk_d       = rk_q;
    rnd_d      = rnd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    en_key_d   = en_key_q;
`ifdef AES_LAST_KEY_OUT_EN
    last_key_d = last_key_q;
`endif
    unique case (st_q)
      StIdle: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = data ^ key;
          rk_d    = key;
          rnd_d   = 4'd1;
          busy_d  = 1'b1;
          st_d    = StRound;
        end
      end
      StRound: begin
        if (rnd_q >= 4'd1 && rnd_q < LastRnd) begin
          state_d = mc ^ rk_next;
          rk_d    = rk_next;
          rnd_d   = rnd_q + 4'd1;
          if (rnd_q == LastRnd - 4'd1) st_d = StFinal;
        end else begin
          st_d   = StIdle;
          busy_d = 1'b0;
          rnd_d  = 4'd0;
        end
      end
      StFinal: begin
        if (rnd_q == LastRnd) begin
          en_key_d   = sr ^ rk_next;
`ifdef AES_LAST_KEY_OUT_EN
          last_key_d = rk_next;
`endif
          done_d     = 1'b1;
        end
        st_d   = StIdle;
        busy_d = 1'b0;
        rnd_d  = 4'd0;
      end
      default: begin
        st_d   = StIdle;
        busy_d = 1'b0;
        rnd_d  = 4'd0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= StIdle;
      state_q    <= '0;
      rk_q       <= '0;
      rnd_q      <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      en_key_q   <= '0;
`ifdef AES_LAST_KEY_OUT_EN
      last_key_q <= '0;
`endif
    end else begin
      st_q       <= st_d;
      state_q    <= state_d;
      rk_q       <= rk_d;
      rnd_q      <= rnd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      en_key_q   <= en_key_d;
`ifdef AES_LAST_KEY_OUT_EN
      last_key_q <= last_key_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign en_key   = en_key_q;
`ifdef AES_LAST_KEY_OUT_EN
  assign last_key = last_key_q;
`endif

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Directed bench for aes128_encrypt_iter using FIPS-197 vectors.
// Optional feature macro: AES_LAST_KEY_OUT_EN enables last_key checks.
module tb_aes128_encrypt_iter;

  localparam logic [0:127] KeyC1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] DatC1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CtC1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] KeyB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] DatB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] CtB   = 128'h3925841d02dc09fbdc118597196a0b32;
`ifdef AES_LAST_KEY_OUT_EN
  localparam logic [0:127] LkC1  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [0:127] LkB   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [0:127] key;
  logic [0:127] data;
  logic         busy;
  logic         done;
  logic [0:127] en_key;
`ifdef AES_LAST_KEY_OUT_EN
  logic [0:127] last_key;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  aes128_encrypt_iter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key      (key),
    .data     (data),
    .busy     (busy),
    .done     (done),
    .en_key   (en_key)
`ifdef AES_LAST_KEY_OUT_EN
    ,
    .last_key (last_key)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge after the done cycle.
  task automatic run_single(input string tag, input logic [0:127] k, input logic [0:127] d,
                            input logic [0:127] ct);
    key   = k;
    data  = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("%s_busy[%0d]", tag, i), busy, 1);
      chk($sformatf("%s_nodone[%0d]", tag, i), done, 0);
      @(negedge clk);
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_ct"}, en_key, ct);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_ct_hold"}, en_key, ct);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    key   = '0;
    data  = '0;

    // Reset then idle.
    repeat (3) begin
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ct", en_key, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("idle_busy[%0d]", i), busy, 0);
      chk($sformatf("idle_done[%0d]", i), done, 0);
      chk($sformatf("idle_ct[%0d]", i), en_key, 0);
    end
`ifdef AES_LAST_KEY_OUT_EN
    chk("idle_lk", last_key, 0);
`endif

    // FIPS-197 C.1 and Appendix B.
    run_single("c1", KeyC1, DatC1, CtC1);
`ifdef AES_LAST_KEY_OUT_EN
    chk("c1_lk", last_key, LkC1);
`endif
    run_single("appb", KeyB, DatB, CtB);
`ifdef AES_LAST_KEY_OUT_EN
    chk("appb_lk", last_key, LkB);
`endif

    // Start while busy is ignored; key/data change mid-run.
    key   = KeyB;
    data  = DatB;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    key   = KeyC1;
    data  = DatC1;
    @(negedge clk);
    start = 1'b0;
    key   = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    data  = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    chk("ign_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("ign_nodone[%0d]", i), done, 0);
    end
    @(negedge clk);
    chk("ign_done", done, 1);
    chk("ign_ct", en_key, CtB);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk($sformatf("ign_single_done[%0d]", i), done, 0);
      chk($sformatf("ign_idle[%0d]", i), busy, 0);
    end

    // Back-to-back with start held high.
    key   = KeyC1;
    data  = DatC1;
    start = 1'b1;
    @(negedge clk);
    key   = KeyB;
    data  = DatB;
    chk("b2b_old_ct", en_key, CtB);
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_nodone1[%0d]", i), done, 0);
    end
    @(negedge clk);
    chk("b2b_done1", done, 1);
    chk("b2b_ct1", en_key, CtC1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_nodone2[%0d]", i), done, 0);
      chk($sformatf("b2b_busy2[%0d]", i), busy, 1);
      chk($sformatf("b2b_hold[%0d]", i), en_key, CtC1);
    end
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done2", done, 1);
    chk("b2b_ct2", en_key, CtB);
    @(negedge clk);
    chk("b2b_end_done", done, 0);
    chk("b2b_end_busy", busy, 0);

    // Abort by reset in the middle of an operation.
    key   = KeyB;
    data  = DatB;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ct", en_key, 0);
`ifdef AES_LAST_KEY_OUT_EN
    chk("abort_lk", last_key, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk($sformatf("abort_nodone[%0d]", i), done, 0);
      chk($sformatf("abort_ct0[%0d]", i), en_key, 0);
      chk($sformatf("abort_idle[%0d]", i), busy, 0);
    end
    run_single("post_abort", KeyC1, DatC1, CtC1);
`ifdef AES_LAST_KEY_OUT_EN
    chk("post_abort_lk", last_key, LkC1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
